line_buf_win_ctrl: RTL and testbench

// - Sequencer for the 1-bit two-line shift RAM in the Sobel edge path.
// - Tracks frame position from the per-frame sync strobes and gates the RAM's clken/href.
// - Suppresses the 3x3 window output until two full lines are buffered, and flags malformed lines.
// - Sits between the binarisation stage and line_shift_ram_1bit / the 3x3 matrix builder.

---
 rtl/line_buf_win_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_line_buf_win_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_win_ctrl.sv
// rtl/line_buf_win_ctrl.sv - frame/line sequencer for the 1-bit two-line shift RAM of the Sobel path
//
// Tracks frame position from the per_frame_* strobes, gates clken/href into the
// two-line shift RAM, and gates the 3x3 window strobes (delayed by PIPE_LAT) so
// the matrix builder only sees pixels once two full lines are buffered.
//
// Optional feature macro: BORDER_MASK_EN
//   defined   - matrix_frame_clken is also suppressed for column 0 and column
//               IMG_H_DISP-1 of every line, so no edge bits appear on the side borders.
//   undefined - border columns pass through unchanged.
//
// Ports
//   clock               in   1       system clock
//   reset               in   1       synchronous, active-high
//   per_frame_vsync     in   1       frame sync; rising edge starts a new frame
//   per_frame_href      in   1       line active
//   per_frame_clken     in   1       pixel valid
//   ram_href            out  1       href to the line RAM (FILL/RUN only)
//   ram_clken           out  1       clken to the line RAM (FILL/RUN, column in range)
//   matrix_frame_vsync  out  1       per_frame_vsync delayed PIPE_LAT
//   matrix_frame_href   out  1       href delayed PIPE_LAT, gated by window validity
//   matrix_frame_clken  out  1       clken delayed PIPE_LAT, gated by window validity
//   col_cnt             out  ADDR_W  pixels accepted in the current line
//   row_cnt             out  10      lines completed in the current frame
//   line_len_err        out  1       sticky: a line ended with col_cnt != IMG_H_DISP
//   frame_done          out  1       one-cycle pulse when row_cnt reaches IMG_V_DISP

module line_buf_win_ctrl #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int ADDR_W     = 10,
    parameter int PIPE_LAT   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    output logic              ram_href,
    output logic              ram_clken,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [ADDR_W-1:0] col_cnt,
    output logic [9:0]        row_cnt,
    output logic              line_len_err,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   H_LEN   = IMG_H_DISP[ADDR_W:0];
    localparam logic [9:0]        V_LEN   = IMG_V_DISP[9:0];
    localparam logic [ADDR_W-1:0] COL_MAX = '1;
`ifdef BORDER_MASK_EN
    localparam int                H_LAST_I = IMG_H_DISP - 1;
    localparam logic [ADDR_W:0]   H_LAST   = H_LAST_I[ADDR_W:0];
`endif

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [ADDR_W-1:0]   col_cnt_q, col_cnt_d;
    logic [9:0]          row_cnt_q, row_cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [PIPE_LAT-1:0] vs_sr_q, vs_sr_d;
    logic [PIPE_LAT-1:0] hr_sr_q, hr_sr_d;
    logic [PIPE_LAT-1:0] ck_sr_q, ck_sr_d;

    logic       vsync_rise;
    logic       href_fall;
    logic       active;
    logic       line_active;
    logic       win_valid;
    logic       col_in_range;
    logic       ck_in;
    logic [9:0] row_next;

    // Edge detects against the previous-cycle copies of the strobes.
    assign vsync_rise   = per_frame_vsync & ~vsync_q;
    assign href_fall    = href_q & ~per_frame_href;
    assign active       = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign row_next     = row_cnt_q + 10'd1;
    assign col_in_range = ({1'b0, col_cnt_q} < H_LEN);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state ----------------
    always_comb begin
        state_d = state_q;
        if (vsync_rise) begin
            // A new frame always restarts the fill, whatever was in progress.
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL, ST_RUN: begin
                    if (href_fall) begin
                        if (row_next == V_LEN) begin
                            state_d = ST_DONE;
                        end else if (row_next >= 10'd2) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        line_active = active & ~vsync_rise;
        win_valid   = (state_q == ST_RUN) & ~vsync_rise;
        ram_href    = per_frame_href & line_active;
        // Pixels past the expected width never reach the RAM, so its address cannot wrap.
        ram_clken   = per_frame_clken & line_active & col_in_range;
    end

    // ---------------- Counters and status ----------------
    always_comb begin
        vsync_d   = per_frame_vsync;
        href_d    = per_frame_href;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        if (vsync_rise) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
            err_d     = 1'b0;
        end else if (active) begin
            if (href_fall) begin
                col_cnt_d = '0;
                row_cnt_d = row_next;
                if ({1'b0, col_cnt_q} != H_LEN) begin
                    err_d = 1'b1;
                end
                if (row_next == V_LEN) begin
                    done_d = 1'b1;
                end
            end else if (per_frame_href && per_frame_clken && (col_cnt_q != COL_MAX)) begin
                col_cnt_d = col_cnt_q + ADDR_W'(1);
            end
        end
    end

    // ---------------- Matrix strobe delay lines ----------------
    always_comb begin
`ifdef BORDER_MASK_EN
        ck_in = per_frame_clken & win_valid &
                (col_cnt_q != '0) & ({1'b0, col_cnt_q} != H_LAST);
`else
        ck_in = per_frame_clken & win_valid;
`endif
        // Gate is applied on entry so it travels with the pixel it belongs to.
        vs_sr_d    = vs_sr_q;
        hr_sr_d    = hr_sr_q;
        ck_sr_d    = ck_sr_q;
        vs_sr_d[0] = per_frame_vsync;
        hr_sr_d[0] = per_frame_href & win_valid;
        ck_sr_d[0] = ck_in;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vs_sr_d[i] = vs_sr_q[i-1];
            hr_sr_d[i] = hr_sr_q[i-1];
            ck_sr_d[i] = ck_sr_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Treat vsync as already high so a level held across reset is not
            // mistaken for a fresh frame start.
            vsync_q   <= 1'b1;
            href_q    <= 1'b0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            vs_sr_q   <= '0;
            hr_sr_q   <= '0;
            ck_sr_q   <= '0;
        end else begin
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            vs_sr_q   <= vs_sr_d;
            hr_sr_q   <= hr_sr_d;
            ck_sr_q   <= ck_sr_d;
        end
    end

    assign matrix_frame_vsync = vs_sr_q[PIPE_LAT-1];
    assign matrix_frame_href  = hr_sr_q[PIPE_LAT-1];
    assign matrix_frame_clken = ck_sr_q[PIPE_LAT-1];
    assign col_cnt            = col_cnt_q;
    assign row_cnt            = row_cnt_q;
    assign line_len_err       = err_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_line_buf_win_ctrl.sv
// tb/tb_line_buf_win_ctrl.sv - randomized scoreboard bench for line_buf_win_ctrl

module tb_line_buf_win_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 4;
    localparam int PL = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vs = 1'b0, hr = 1'b0, ck = 1'b0;
    logic          ram_href, ram_clken;
    logic          m_vs, m_hr, m_ck;
    logic [AW-1:0] col_cnt;
    logic [9:0]    row_cnt;
    logic          line_len_err, frame_done;

    line_buf_win_ctrl #(
        .IMG_H_DISP(H), .IMG_V_DISP(V), .ADDR_W(AW), .PIPE_LAT(PL)
    ) dut (
        .clock(clock), .reset(reset),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .ram_href(ram_href), .ram_clken(ram_clken),
        .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hr), .matrix_frame_clken(m_ck),
        .col_cnt(col_cnt), .row_cnt(row_cnt),
        .line_len_err(line_len_err), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected cycle numbers of each output strobe:
    // 0 ram_clken, 1 ram_href, 2 matrix_clken, 3 matrix_href, 4 matrix_vsync, 5 frame_done
    int    exp_q[6][$];
    string nm[6] = '{"ram_clken", "ram_href", "matrix_clken", "matrix_href", "matrix_vsync", "frame_done"};

    // Reference frame model
    bit in_frame = 0;
    bit done_f   = 0;
    bit err_exp  = 0;
    int lines_done = 0;
    int rows_exp   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input bit v, input bit h, input bit c);
        vs = v; hr = h; ck = c;
        @(posedge clock);
        #1;
    endtask

    function automatic bit masked(input int j);
`ifdef BORDER_MASK_EN
        return (j == 0) || (j == H - 1);
`else
        return (j < 0);
`endif
    endfunction

    function automatic void model_rise();
        in_frame   = 1;
        done_f     = 0;
        err_exp    = 0;
        lines_done = 0;
        rows_exp   = 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick(0, 0, 0);
        reset = 1'b0;
        in_frame = 0; done_f = 0; err_exp = 0; lines_done = 0; rows_exp = 0;
        for (int i = 0; i < 6; i++) exp_q[i].delete();
        check("rst_col_cnt", int'(col_cnt), 0);
        check("rst_row_cnt", int'(row_cnt), 0);
        check("rst_line_len_err", int'(line_len_err), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_matrix_vsync", int'(m_vs), 0);
        check("rst_matrix_href", int'(m_hr), 0);
        check("rst_matrix_clken", int'(m_ck), 0);
        check("rst_ram_href", int'(ram_href), 0);
        check("rst_ram_clken", int'(ram_clken), 0);
    endtask

    task automatic send_vsync();
        int n;
        n = cyc;
        model_rise();
        exp_q[4].push_back(n + PL);
        exp_q[4].push_back(n + 1 + PL);
        tick(1, 0, 0);
        check("vs_row_cnt", int'(row_cnt), 0);
        check("vs_col_cnt", int'(col_cnt), 0);
        check("vs_line_len_err", int'(line_len_err), 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
    endtask

    // One line of npix accepted pixels with random clken gaps. With abort set,
    // the line ends on a cycle where vsync rises as href falls.
    task automatic send_line(input int npix, input bit abort);
        int  k, n, j, exp_col;
        bit  act, win, c;
        k   = lines_done;
        act = in_frame && !done_f;
        win = act && (k >= 2);
        j   = 0;
        while (j < npix) begin
            n = cyc;
            c = ($urandom_range(0, 3) != 0);
            if (act) exp_q[1].push_back(n);
            if (win) exp_q[3].push_back(n + PL);
            if (c) begin
                if (act && j < H)        exp_q[0].push_back(n);
                if (win && !masked(j))   exp_q[2].push_back(n + PL);
                j++;
            end
            tick(0, 1, c);
        end
        n = cyc;
        if (abort) begin
            model_rise();
            exp_q[4].push_back(n + PL);
            exp_q[4].push_back(n + 1 + PL);
            tick(1, 0, 0);
            check("abort_row_cnt", int'(row_cnt), 0);
            check("abort_col_cnt", int'(col_cnt), 0);
            tick(1, 0, 0);
            tick(0, 0, 0);
        end else begin
            exp_col = act ? ((npix > 15) ? 15 : npix) : 0;
            check("fall_col_cnt", int'(col_cnt), exp_col);
            tick(0, 0, 0);
            if (act) begin
                lines_done++;
                rows_exp = lines_done;
                if (npix != H) err_exp = 1;
                if (lines_done == V) begin
                    exp_q[5].push_back(n + 1);
                    done_f = 1;
                end
            end
            check("line_row_cnt", int'(row_cnt), rows_exp);
            check("line_col_clear", int'(col_cnt), 0);
            check("line_len_err", int'(line_len_err), int'(err_exp));
        end
        repeat ($urandom_range(1, 3)) tick(0, 0, 0);
    endtask

    // Scoreboard monitor: every strobe the DUT raises must match the next expected cycle.
    always @(negedge clock) begin
        logic [5:0] obs;
        if (!reset) begin
            obs = {frame_done, m_vs, m_hr, m_ck, ram_href, ram_clken};
            for (int i = 0; i < 6; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed: got 0 expected 1 at cycle %0d", nm[i], exp_q[i][0]);
                    void'(exp_q[i].pop_front());
                end
                if (obs[i]) begin
                    checks++;
                    if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
                        void'(exp_q[i].pop_front());
                    end else begin
                        errors++;
                        $display("FAIL %s unexpected: got 1 expected 0 at cycle %0d", nm[i], cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clock); #1;
        tick(0, 0, 0);
        do_reset();

        // Lines before any vsync are ignored.
        send_line(H, 0);

        // Nominal frame.
        send_vsync();
        repeat (V) send_line(H, 0);
        // Extra line in DONE is ignored.
        send_line(H, 0);

        // Short line then over-long line.
        send_vsync();
        send_line(7, 0);
        send_line(10, 0);
        send_line(H, 0);
        send_line(H, 0);

        // vsync rise coincident with href fall during the third line.
        send_vsync();
        send_line(H, 0);
        send_line(H, 0);
        send_line(3, 1);
        repeat (V) send_line(H, 0);

        // Reset while in RUN.
        send_vsync();
        repeat (3) send_line(H, 0);
        repeat (PL + 2) tick(0, 0, 0);
        do_reset();
        send_line(H, 0);
        send_vsync();
        repeat (V) send_line(H, 0);

        // Random frames.
        repeat (5) begin
            send_vsync();
            repeat ($urandom_range(1, 6)) send_line($urandom_range(5, 11), 0);
        end

        repeat (PL + 4) tick(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL %s drain: got %0d pending expected 0", nm[i], exp_q[i].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
